// File: rtl/ram_access_mux.sv
// Registers one of eight RAM requesters onto a single RAM port and routes read data back.
// Compressed sources are decoded only when RAM_ACCESS_MUX_RVC_EN is defined.
module ram_access_mux #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [6:0]        OPCODE,
    input  logic [31:0]       iIR,
    input  logic [15:0]       iIR_C,

    input  logic              iRAM_CE_I,
    input  logic              iRAM_RD_I,
    input  logic              iRAM_WR_I,
    input  logic [ADDR_W-1:0] iRAM_ADDR_I,
    input  logic [DATA_W-1:0] iRAM_DATA_WR_I,
    output logic [DATA_W-1:0] oRAM_DATA_RD_I,

    input  logic              iRAM_CE_S,
    input  logic              iRAM_RD_S,
    input  logic              iRAM_WR_S,
    input  logic [ADDR_W-1:0] iRAM_ADDR_S,
    input  logic [DATA_W-1:0] iRAM_DATA_WR_S,
    output logic [DATA_W-1:0] oRAM_DATA_RD_S,

    input  logic              iRAM_CE_A,
    input  logic              iRAM_RD_A,
    input  logic              iRAM_WR_A,
    input  logic [ADDR_W-1:0] iRAM_ADDR_A,
    input  logic [DATA_W-1:0] iRAM_DATA_WR_A,
    output logic [DATA_W-1:0] oRAM_DATA_RD_A,

    input  logic              iRAM_CE_F,
    input  logic              iRAM_RD_F,
    input  logic              iRAM_WR_F,
    input  logic [ADDR_W-1:0] iRAM_ADDR_F,
    input  logic [DATA_W-1:0] iRAM_DATA_WR_F,
    output logic [DATA_W-1:0] oRAM_DATA_RD_F,

    input  logic              iRAM_CE_CI,
    input  logic              iRAM_RD_CI,
    input  logic              iRAM_WR_CI,
    input  logic [ADDR_W-1:0] iRAM_ADDR_CI,
    output logic [DATA_W-1:0] oRAM_DATA_RD_CI,

    input  logic              iRAM_CE_CSS,
    input  logic              iRAM_RD_CSS,
    input  logic              iRAM_WR_CSS,
    input  logic [ADDR_W-1:0] iRAM_ADDR_CSS,
    input  logic [DATA_W-1:0] iRAM_DATA_WR_CSS,

    input  logic              iRAM_CE_CL,
    input  logic              iRAM_RD_CL,
    input  logic              iRAM_WR_CL,
    input  logic [ADDR_W-1:0] iRAM_ADDR_CL,
    output logic [DATA_W-1:0] oRAM_DATA_RD_CL,

    input  logic              iRAM_CE_CS,
    input  logic              iRAM_RD_CS,
    input  logic              iRAM_WR_CS,
    input  logic [ADDR_W-1:0] iRAM_ADDR_CS,
    input  logic [DATA_W-1:0] iRAM_DATA_WR_CS,

    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic              oRAM_WR,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    output logic [DATA_W-1:0] oRAM_DATA_WR,
    input  logic [DATA_W-1:0] iRAM_DATA_RD
);

    localparam logic [3:0] SRC_NONE = 4'd0;
    localparam logic [3:0] SRC_I    = 4'd1;
    localparam logic [3:0] SRC_S    = 4'd2;
    localparam logic [3:0] SRC_A    = 4'd3;
    localparam logic [3:0] SRC_F    = 4'd4;
    localparam logic [3:0] SRC_CI   = 4'd5;
    localparam logic [3:0] SRC_CSS  = 4'd6;
    localparam logic [3:0] SRC_CL   = 4'd7;
    localparam logic [3:0] SRC_CS   = 4'd8;

    localparam logic [2:0] SEL_I  = 3'd1;
    localparam logic [2:0] SEL_S  = 3'd2;
    localparam logic [2:0] SEL_A  = 3'd3;
    localparam logic [2:0] SEL_F  = 3'd4;
    localparam logic [2:0] SEL_CI = 3'd5;
    localparam logic [2:0] SEL_CL = 3'd7;

    logic [3:0]        src_d;
    logic [2:0]        sel_d, sel_q;
    logic              ce_d, ce_q;
    logic              rd_d, rd_q;
    logic              wr_d, wr_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] data_d, data_q;

    always_comb begin
        src_d = SRC_NONE;
        if (iIR[1:0] == 2'b11) begin
            case (OPCODE)
                7'b0000011: src_d = SRC_I;
                7'b0100011: src_d = SRC_S;
                7'b0101111: src_d = SRC_A;
                7'b0000111,
                7'b0100111: src_d = SRC_F;
                default:    src_d = SRC_NONE;
            endcase
        end else begin
`ifdef RAM_ACCESS_MUX_RVC_EN
            case ({iIR_C[1:0], iIR_C[15:13]})
                5'b10_010: src_d = SRC_CI;
                5'b10_110: src_d = SRC_CSS;
                5'b00_010: src_d = SRC_CL;
                5'b00_110: src_d = SRC_CS;
                default:   src_d = SRC_NONE;
            endcase
`else
            src_d = SRC_NONE;
`endif
        end
    end

    // CS reuses the CSS code: neither returns read data, so routing is unaffected
    always_comb begin
        sel_d = (src_d == SRC_CS) ? 3'd6 : src_d[2:0];
    end

    always_comb begin
        ce_d   = 1'b0;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        case (src_d)
            SRC_I: begin
                ce_d   = iRAM_CE_I;
                rd_d   = iRAM_RD_I;
                wr_d   = iRAM_WR_I;
                addr_d = iRAM_ADDR_I;
                data_d = iRAM_DATA_WR_I;
            end
            SRC_S: begin
                ce_d   = iRAM_CE_S;
                rd_d   = iRAM_RD_S;
                wr_d   = iRAM_WR_S;
                addr_d = iRAM_ADDR_S;
                data_d = iRAM_DATA_WR_S;
            end
            SRC_A: begin
                ce_d   = iRAM_CE_A;
                rd_d   = iRAM_RD_A;
                wr_d   = iRAM_WR_A;
                addr_d = iRAM_ADDR_A;
                data_d = iRAM_DATA_WR_A;
            end
            SRC_F: begin
                ce_d   = iRAM_CE_F;
                rd_d   = iRAM_RD_F;
                wr_d   = iRAM_WR_F;
                addr_d = iRAM_ADDR_F;
                data_d = iRAM_DATA_WR_F;
            end
`ifdef RAM_ACCESS_MUX_RVC_EN
            SRC_CI: begin
                ce_d   = iRAM_CE_CI;
                rd_d   = iRAM_RD_CI;
                wr_d   = iRAM_WR_CI;
                addr_d = iRAM_ADDR_CI;
                data_d = '0;
            end
            SRC_CSS: begin
                ce_d   = iRAM_CE_CSS;
                rd_d   = iRAM_RD_CSS;
                wr_d   = iRAM_WR_CSS;
                addr_d = iRAM_ADDR_CSS;
                data_d = iRAM_DATA_WR_CSS;
            end
            SRC_CL: begin
                ce_d   = iRAM_CE_CL;
                rd_d   = iRAM_RD_CL;
                wr_d   = iRAM_WR_CL;
                addr_d = iRAM_ADDR_CL;
                data_d = '0;
            end
            SRC_CS: begin
                ce_d   = iRAM_CE_CS;
                rd_d   = iRAM_RD_CS;
                wr_d   = iRAM_WR_CS;
                addr_d = iRAM_ADDR_CS;
                data_d = iRAM_DATA_WR_CS;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            sel_q  <= '0;
            ce_q   <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            sel_q  <= sel_d;
            ce_q   <= ce_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign oRAM_CE      = ce_q;
    assign oRAM_RD      = rd_q;
    assign oRAM_WR      = wr_q;
    assign oRAM_ADDR    = addr_q;
    assign oRAM_DATA_WR = data_q;

    assign oRAM_DATA_RD_I = (rd_q && sel_q == SEL_I) ? iRAM_DATA_RD : '0;
    assign oRAM_DATA_RD_S = (rd_q && sel_q == SEL_S) ? iRAM_DATA_RD : '0;
    assign oRAM_DATA_RD_A = (rd_q && sel_q == SEL_A) ? iRAM_DATA_RD : '0;
    assign oRAM_DATA_RD_F = (rd_q && sel_q == SEL_F) ? iRAM_DATA_RD : '0;

`ifdef RAM_ACCESS_MUX_RVC_EN
    assign oRAM_DATA_RD_CI = (rd_q && sel_q == SEL_CI) ? iRAM_DATA_RD : '0;
    assign oRAM_DATA_RD_CL = (rd_q && sel_q == SEL_CL) ? iRAM_DATA_RD : '0;

    logic unused_bits;
    assign unused_bits = ^{iIR[31:2], iIR_C[12:2]};
`else
    assign oRAM_DATA_RD_CI = '0;
    assign oRAM_DATA_RD_CL = '0;

    // Compressed ports stay on the boundary but feed nothing in this build
    logic unused_bits;
    assign unused_bits = ^{iIR[31:2], iIR_C,
                           iRAM_CE_CI, iRAM_RD_CI, iRAM_WR_CI, iRAM_ADDR_CI,
                           iRAM_CE_CSS, iRAM_RD_CSS, iRAM_WR_CSS,
                           iRAM_ADDR_CSS, iRAM_DATA_WR_CSS,
                           iRAM_CE_CL, iRAM_RD_CL, iRAM_WR_CL, iRAM_ADDR_CL,
                           iRAM_CE_CS, iRAM_RD_CS, iRAM_WR_CS,
                           iRAM_ADDR_CS, iRAM_DATA_WR_CS};
`endif

endmodule

// File: tb/tb_ram_access_mux.sv
// Directed bench for ram_access_mux: scoreboard of expected RAM-port states
// plus read-data routing checks after every registered access.
module tb_ram_access_mux;

    localparam int AW = 8;
    localparam int DW = 32;

    localparam int X_I   = 0;
    localparam int X_S   = 1;
    localparam int X_A   = 2;
    localparam int X_F   = 3;
    localparam int X_CI  = 4;
    localparam int X_CSS = 5;
    localparam int X_CL  = 6;
    localparam int X_CS  = 7;
    localparam int X_NONE = -1;

    typedef struct {
        logic          ce;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            route;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = '0;
    logic [31:0]   ir = 32'h3;
    logic [15:0]   ir_c = '0;
    logic          s_ce [8];
    logic          s_rd [8];
    logic          s_wr [8];
    logic [AW-1:0] s_addr [8];
    logic [DW-1:0] s_data [8];
    logic [DW-1:0] ram_rd = '0;

    logic [DW-1:0] rd_i, rd_s, rd_a, rd_f, rd_ci, rd_cl;
    logic          o_ce, o_rd, o_wr;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;

    exp_t          sb[$];
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    ram_access_mux #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .iCLK(clk), .iRST(rst_n), .OPCODE(opcode), .iIR(ir), .iIR_C(ir_c),
        .iRAM_CE_I(s_ce[0]), .iRAM_RD_I(s_rd[0]), .iRAM_WR_I(s_wr[0]),
        .iRAM_ADDR_I(s_addr[0]), .iRAM_DATA_WR_I(s_data[0]),
        .oRAM_DATA_RD_I(rd_i),
        .iRAM_CE_S(s_ce[1]), .iRAM_RD_S(s_rd[1]), .iRAM_WR_S(s_wr[1]),
        .iRAM_ADDR_S(s_addr[1]), .iRAM_DATA_WR_S(s_data[1]),
        .oRAM_DATA_RD_S(rd_s),
        .iRAM_CE_A(s_ce[2]), .iRAM_RD_A(s_rd[2]), .iRAM_WR_A(s_wr[2]),
        .iRAM_ADDR_A(s_addr[2]), .iRAM_DATA_WR_A(s_data[2]),
        .oRAM_DATA_RD_A(rd_a),
        .iRAM_CE_F(s_ce[3]), .iRAM_RD_F(s_rd[3]), .iRAM_WR_F(s_wr[3]),
        .iRAM_ADDR_F(s_addr[3]), .iRAM_DATA_WR_F(s_data[3]),
        .oRAM_DATA_RD_F(rd_f),
        .iRAM_CE_CI(s_ce[4]), .iRAM_RD_CI(s_rd[4]), .iRAM_WR_CI(s_wr[4]),
        .iRAM_ADDR_CI(s_addr[4]), .oRAM_DATA_RD_CI(rd_ci),
        .iRAM_CE_CSS(s_ce[5]), .iRAM_RD_CSS(s_rd[5]), .iRAM_WR_CSS(s_wr[5]),
        .iRAM_ADDR_CSS(s_addr[5]), .iRAM_DATA_WR_CSS(s_data[5]),
        .iRAM_CE_CL(s_ce[6]), .iRAM_RD_CL(s_rd[6]), .iRAM_WR_CL(s_wr[6]),
        .iRAM_ADDR_CL(s_addr[6]), .oRAM_DATA_RD_CL(rd_cl),
        .iRAM_CE_CS(s_ce[7]), .iRAM_RD_CS(s_rd[7]), .iRAM_WR_CS(s_wr[7]),
        .iRAM_ADDR_CS(s_addr[7]), .iRAM_DATA_WR_CS(s_data[7]),
        .oRAM_CE(o_ce), .oRAM_RD(o_rd), .oRAM_WR(o_wr),
        .oRAM_ADDR(o_addr), .oRAM_DATA_WR(o_data),
        .iRAM_DATA_RD(ram_rd)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < 8; i++) begin
            s_ce[i] = 1'b0;
            s_rd[i] = 1'b0;
            s_wr[i] = 1'b0;
            s_addr[i] = '0;
            s_data[i] = '0;
        end
    endtask

    task automatic set_src(input int x, input logic ce, input logic rd,
                           input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        s_ce[x] = ce;
        s_rd[x] = rd;
        s_wr[x] = wr;
        s_addr[x] = a;
        s_data[x] = d;
    endtask

    // Bench model: what the RAM port must show after the edge for a chosen source
    task automatic push_exp(input int x);
        exp_t e;
        if (x == X_NONE) begin
            e.ce = 1'b0;
            e.rd = 1'b0;
            e.wr = 1'b0;
        end else begin
            e.ce = s_ce[x];
            e.rd = s_rd[x];
            e.wr = s_wr[x];
            m_addr = s_addr[x];
            m_data = (x == X_CI || x == X_CL) ? '0 : s_data[x];
        end
        e.addr = m_addr;
        e.data = m_data;
        e.route = x;
        sb.push_back(e);
    endtask

    task automatic chk_route(input string tag, input int route,
                             input logic rd, input logic [DW-1:0] v);
        chk({tag, "_rd_i"}, rd_i, (rd && route == X_I) ? v : '0);
        chk({tag, "_rd_s"}, rd_s, (rd && route == X_S) ? v : '0);
        chk({tag, "_rd_a"}, rd_a, (rd && route == X_A) ? v : '0);
        chk({tag, "_rd_f"}, rd_f, (rd && route == X_F) ? v : '0);
        chk({tag, "_rd_ci"}, rd_ci, (rd && route == X_CI) ? v : '0);
        chk({tag, "_rd_cl"}, rd_cl, (rd && route == X_CL) ? v : '0);
    endtask

    task automatic step(input string tag, input int x, input logic [DW-1:0] v);
        exp_t e;
        push_exp(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ce"}, {31'd0, o_ce}, {31'd0, e.ce});
            chk({tag, "_rd"}, {31'd0, o_rd}, {31'd0, e.rd});
            chk({tag, "_wr"}, {31'd0, o_wr}, {31'd0, e.wr});
            chk({tag, "_addr"}, {24'd0, o_addr}, {24'd0, e.addr});
            chk({tag, "_data"}, o_data, e.data);
            ram_rd = v;
            #1;
            chk_route(tag, e.route, e.rd, v);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ce"}, {31'd0, o_ce}, 32'd0);
        chk({tag, "_rd"}, {31'd0, o_rd}, 32'd0);
        chk({tag, "_wr"}, {31'd0, o_wr}, 32'd0);
        chk({tag, "_addr"}, {24'd0, o_addr}, 32'd0);
        chk({tag, "_data"}, o_data, 32'd0);
        chk_route(tag, X_NONE, 1'b0, 32'd0);
    endtask

    initial begin
        int rvc;
`ifdef RAM_ACCESS_MUX_RVC_EN
        rvc = 1;
`else
        rvc = 0;
`endif
        clear_src();

        // reset held with a store being requested
        ir = 32'h3;
        opcode = 7'b0100011;
        set_src(X_S, 1, 0, 1, 8'h10, 32'hDEADBEEF);
        ram_rd = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_hold");

        // release with nothing selected
        opcode = 7'b0000000;
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_idle", X_NONE, 32'hA5A5_A5A5);

        opcode = 7'b0100011;
        step("store", X_S, 32'h1111_2222);

        clear_src();
        opcode = 7'b0000011;
        set_src(X_I, 1, 1, 0, 8'h04, 32'h0);
        step("load", X_I, 32'h12345678);

        clear_src();
        opcode = 7'b0101111;
        set_src(X_A, 1, 1, 1, 8'h20, 32'hCAFE_F00D);
        step("amo", X_A, $urandom);

        clear_src();
        opcode = 7'b0000111;
        set_src(X_F, 1, 1, 0, 8'hFF, 32'h0);
        step("flw", X_F, $urandom);

        opcode = 7'b0100111;
        set_src(X_F, 1, 0, 1, 8'h00, 32'hFFFF_FFFF);
        step("fsw", X_F, $urandom);

        // strobes pass through unmodified, even with CE low
        opcode = 7'b0000011;
        set_src(X_I, 0, 1, 0, 8'h3C, 32'h0);
        step("raw_strobe", X_I, $urandom);

        for (int i = 0; i < 8; i++)
            set_src(i, 1, 1, 1, 8'h80 + 8'(i), 32'h5000_0000 + i);
        opcode = 7'b0110011;
        step("unknown", X_NONE, $urandom);

        clear_src();
        ir = 32'h0;
        opcode = 7'b0000000;
        ir_c = 16'h4108;
        set_src(X_CL, 1, 1, 0, 8'h08, 32'h7777_7777);
        step("c_lw", (rvc != 0) ? X_CL : X_NONE, 32'h0BAD_F00D);

        clear_src();
        ir_c = 16'h4002;
        set_src(X_CI, 1, 1, 0, 8'h44, 32'h6666_6666);
        step("c_lwsp", (rvc != 0) ? X_CI : X_NONE, $urandom);

        clear_src();
        ir_c = 16'hC002;
        set_src(X_CSS, 1, 0, 1, 8'h48, 32'h1357_9BDF);
        step("c_swsp", (rvc != 0) ? X_CSS : X_NONE, $urandom);

        clear_src();
        ir_c = 16'hC004;
        set_src(X_CS, 1, 0, 1, 8'h4C, 32'h2468_ACE0);
        step("c_sw", (rvc != 0) ? X_CS : X_NONE, $urandom);

        // reset mid-access: the pending load is dropped
        clear_src();
        ir = 32'h3;
        ir_c = 16'h0;
        opcode = 7'b0000011;
        set_src(X_I, 1, 1, 0, 8'h55, 32'h0);
        step("pre_abort", X_I, 32'h8888_9999);
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        ram_rd = 32'h4444_3333;
        #1;
        chk_route("abort_late", X_NONE, 1'b0, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        m_addr = '0;
        m_data = '0;
        clear_src();
        opcode = 7'b0100011;
        set_src(X_S, 1, 0, 1, 8'h99, 32'h0102_0304);
        step("post_rst", X_S, $urandom);

        opcode = 7'b0000011;
        set_src(X_I, 1, 1, 0, 8'hA0, 32'h0);
        step("post_load", X_I, $urandom);

        if (sb.size() != 0)
            chk("sb_leftover", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
